// File: rtl/mem_port_arbiter_if.sv
// Core fetch/data ports and the shared memory handshake of mem_port_arbiter.
// The master modport is the arbiter's view; slave is the core-plus-memory side.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_ctrl;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        m_req;
    logic        m_we;
    logic [2:0]  m_ctrl;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    logic        err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_ctrl, d_addr, d_wdata, m_ack, m_rdata,
        output i_rdata, i_done, d_rdata, d_done,
        output m_req, m_we, m_ctrl, m_addr, m_wdata, err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_ctrl, d_addr, d_wdata, m_ack, m_rdata,
        input  i_rdata, i_done, d_rdata, d_done,
        input  m_req, m_we, m_ctrl, m_addr, m_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the core's fetch (I) and data (D) ports,
// with a fetch starvation guard and a sticky ack-timeout error.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int unsigned TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [2:0]  CTRL_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [2:0]  m_ctrl_q, m_ctrl_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_done_q, i_done_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_done_q, d_done_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        err_q, err_d;

    logic i_ok, d_ok, streak_full, i_wins, tmo_hit;

    // A port's request is stale in the cycle its done pulse is visible to the core.
    assign i_ok        = bus.i_req & ~i_done_q;
    assign d_ok        = bus.d_req & ~d_done_q;
    assign streak_full = (MAX_D_STREAK > 0) && (streak_q == SW'(MAX_D_STREAK));
    assign i_wins      = i_ok & (~d_ok | streak_full);
    assign tmo_hit     = (ACK_TIMEOUT > 0) && (tmo_q == TW'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_ctrl_d  = m_ctrl_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (i_wins) begin
                    state_d   = GNT_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_ctrl_d  = CTRL_WORD;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                    tmo_d     = '0;
                    streak_d  = '0;
                end else if (d_ok) begin
                    state_d   = GNT_D;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_ctrl_d  = bus.d_ctrl;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    tmo_d     = '0;
                    if (bus.i_req && !streak_full && MAX_D_STREAK > 0) begin
                        streak_d = streak_q + SW'(1);
                    end
                end
            end
            GNT_I, GNT_D: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (bus.m_ack) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (state_q == GNT_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = bus.m_rdata;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = bus.m_rdata;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    tmo_d   = TW'(ACK_TIMEOUT);
                    if (state_q == GNT_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end
                end else if (ACK_TIMEOUT > 0) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_ctrl_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_rdata_q <= '0;
            d_done_q  <= 1'b0;
            streak_q  <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_ctrl_q  <= m_ctrl_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            i_done_q  <= i_done_d;
            d_rdata_q <= d_rdata_d;
            d_done_q  <= d_done_d;
            streak_q  <= streak_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_ctrl  = m_ctrl_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.i_done  = i_done_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_done  = d_done_q;
    assign bus.err     = err_q;

endmodule
